dino_game_engine: RTL
=====================

# dino_game_engine

Per-frame game-state engine that drives the coordinate, `game_over` and `pause` inputs of the VGA display controller and consumes its `screen_ready` and `collision_detected` outputs. Once per video frame it advances dino jump physics and obstacle scrolling, latches collisions into a game-over state, and handles pause and restart buttons. It sits between the board buttons and the display controller, all in the 100 MHz system clock domain.

## Interface
- `DINO_X`, 100: fixed left x of dino.
- `GROUND_Y`, 320: bottom y of dino and obstacle when grounded.
- `OBST_START_X`, 680: obstacle left x after reset or respawn.
- `OBST_SPEED`, 4: obstacle x decrement per frame.
- `JUMP_VELOCITY`, 12: initial upward velocity, pixels/frame.
- `GRAVITY`, 1: velocity decrement per frame.
- `SCORE_WIDTH`, 16: score counter width.
- `clk  input  1`: 100 MHz system clock.
- `reset  input  1`: asynchronous, active-high reset.
- `screen_ready  input  1`: frame-end indication from the display controller; high for several `clk` cycles per frame.
- `collision_detected  input  1`: combinational overlap flag from the display controller.
- `jump_btn  input  1`: raw asynchronous button; jump, or restart when over.
- `pause_btn  input  1`: raw asynchronous button; toggles pause.
- `x_coor  output  32`: dino left x.
- `y_coor  output  32`: dino bottom y.
- `x_coor_obstacle  output  32`: obstacle left x.
- `y_coor_obstacle  output  32`: obstacle bottom y, constant `GROUND_Y`.
- `game_over  output  1`: high in OVER.
- `pause  output  1`: high in PAUSED.
- `score  output  SCORE_WIDTH`: obstacles cleared.

## Operation
- **Frame tick:** `tick` is a single-cycle pulse on the rising edge of `screen_ready`, using a registered previous value.
- **Buttons:**
  - Each button passes through a 2-flop synchronizer, then rising-edge detect, giving a 1-cycle press pulse.
  - A jump press sets `jump_req`. `jump_req` is consumed at the next tick and cleared on any state change.
- **FSM states:** RUN, PAUSED, OVER. Reset state is RUN.
- **RUN, on tick, evaluated in this order:**
  1. If `collision_detected` is 1, go to OVER. Positions do not update on this tick.
  2. Else, dino physics runs. Height `h` (unsigned 9-bit) and velocity `v` (signed 9-bit) are used.
     - If `h==0` and `jump_req`: `v<=JUMP_VELOCITY-GRAVITY`, `h<=JUMP_VELOCITY`.
     - Else if `h>0`: `hn=h+v` computed signed. If `hn<=0`, `h<=0` and `v<=0`. Otherwise `h<=hn` and `v<=v-GRAVITY`.
     - `y_coor=GROUND_Y-h`.
  3. Obstacle scrolling:
     - If `x_coor_obstacle<OBST_SPEED`: `x_coor_obstacle<=OBST_START_X`, and `score` increments, saturating at all-ones.
     - Else: `x_coor_obstacle<=x_coor_obstacle-OBST_SPEED`.
- **RUN, pause press:** go to PAUSED. If a collision tick occurs in the same cycle, OVER wins and the pause press is dropped.
- **PAUSED:**
  - All positions and score are frozen and ticks are ignored.
  - A pause press returns to RUN.
  - Jump presses are discarded.
- **OVER:**
  - Positions and score are frozen.
  - A pause press is ignored.
  - A jump press restarts: positions reset to their reset values, `score<=0`, `h=v=0`, go to RUN.
- **Width:** the upper 32-bit output bits are zero-extended; the internal x is 12-bit.

## Timing
- **Reset values:**
  - `x_coor=DINO_X`, `y_coor=GROUND_Y`.
  - `x_coor_obstacle=OBST_START_X`, `y_coor_obstacle=GROUND_Y`.
  - `game_over=0`, `pause=0`, `score=0`.
  - `h=v=0`, `jump_req=0`, and synchronizer/edge registers 0.
- **Outputs:** all registered. Position updates are visible 1 cycle after the `tick` cycle.
- **Tick latency:** `tick` asserts 1 cycle after `screen_ready` rises. Total latency from `screen_ready` rise to new coordinates is 2 cycles.
- **Button latency:** a button rising edge produces its press pulse 3 cycles later. `pause`/`game_over` change 1 cycle after the press pulse.
- **Frame cadence:** exactly one tick per `screen_ready` high period, however long that period is.
- **Reset mid-operation:** reset asserted at any time returns all outputs to reset values immediately (asynchronous). The first tick after release samples `screen_ready` edges cleanly, because the previous-value register resets to 0.

## Test plan
- **Jump arc:** reset, then jump press, then 30 ticks. Required: `y_coor` sequence 308, 297, 287, …, peaks at 242, and returns to exactly 320 with `v=0`. A second press while airborne is ignored.
- **Scroll and respawn:** 170 ticks, no collision. Required: `x_coor_obstacle` goes 676, 672, … down to 0, then 680 on the next tick, with `score` going 0→1 on that tick.
- **Collision latch:** hold `collision_detected=1` during a tick. Required: `game_over=1`, positions unchanged, and later ticks leave all outputs frozen.
- **Restart:** in OVER, jump press. Required: `x_coor_obstacle=680`, `y_coor=320`, `score=0`, `game_over=0`.
- **Pause:** pause press in RUN, then 10 ticks, then pause press. Required: outputs frozen while `pause=1`, and scrolling resumes from the frozen x. Collision and pause in the same cycle gives `game_over=1`, `pause=0`.
- **Async reset:** assert `reset` mid-jump, between clock edges. Required: all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/dino_game_if.sv
// Signals between the dino game engine and the VGA display controller / board buttons.
// The master modport is the engine side.
interface dino_game_if #(
  parameter int SCORE_WIDTH = 16
);
  logic                   screen_ready;
  logic                   collision_detected;
  logic                   jump_btn;
  logic                   pause_btn;
  logic [31:0]            x_coor;
  logic [31:0]            y_coor;
  logic [31:0]            x_coor_obstacle;
  logic [31:0]            y_coor_obstacle;
  logic                   game_over;
  logic                   pause;
  logic [SCORE_WIDTH-1:0] score;

  modport master (
    input  screen_ready, collision_detected, jump_btn, pause_btn,
    output x_coor, y_coor, x_coor_obstacle, y_coor_obstacle, game_over, pause, score
  );

  modport slave (
    output screen_ready, collision_detected, jump_btn, pause_btn,
    input  x_coor, y_coor, x_coor_obstacle, y_coor_obstacle, game_over, pause, score
  );
endinterface

// File: rtl/dino_game_engine.sv
// Per-frame game state: dino jump physics, obstacle scrolling, score,
// and the RUN / PAUSED / OVER sequencing driven by the board buttons.
module dino_game_engine #(
  parameter int DINO_X        = 100,
  parameter int GROUND_Y      = 320,
  parameter int OBST_START_X  = 680,
  parameter int OBST_SPEED    = 4,
  parameter int JUMP_VELOCITY = 12,
  parameter int GRAVITY       = 1,
  parameter int SCORE_WIDTH   = 16
) (
  input logic         clk,
  input logic         reset,
  dino_game_if.master bus
);

  typedef enum logic [1:0] {RUN, PAUSED, OVER} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             btn_s1_q, btn_s1_d;   // bit 0 jump, bit 1 pause
  logic [1:0]             btn_s2_q, btn_s2_d;
  logic [1:0]             btn_prev_q, btn_prev_d;
  logic [1:0]             press_q, press_d;
  logic                   sr_prev_q, sr_prev_d;
  logic                   tick_q, tick_d;
  logic                   jump_req_q, jump_req_d;
  logic [8:0]             h_q, h_d;
  logic signed [8:0]      v_q, v_d;
  logic [11:0]            y_q, y_d;
  logic [11:0]            xo_q, xo_d;
  logic [SCORE_WIDTH-1:0] score_q, score_d;
  logic                   game_over_q, game_over_d;
  logic                   pause_q, pause_d;

  logic                   jump_press, pause_press, jump_pend;
  logic signed [9:0]      hn;

  assign jump_press  = press_q[0];
  assign pause_press = press_q[1];
  assign jump_pend   = jump_req_q | jump_press;
  assign hn          = $signed({1'b0, h_q}) + $signed({v_q[8], v_q});

  always_comb begin
    btn_s1_d    = {bus.pause_btn, bus.jump_btn};
    btn_s2_d    = btn_s1_q;
    btn_prev_d  = btn_s2_q;
    press_d     = btn_s2_q & ~btn_prev_q;
    sr_prev_d   = bus.screen_ready;
    tick_d      = bus.screen_ready & ~sr_prev_q;
    state_d     = state_q;
    jump_req_d  = jump_req_q;
    h_d         = h_q;
    v_d         = v_q;
    xo_d        = xo_q;
    score_d     = score_q;

    case (state_q)
      RUN: begin
        if (tick_q && bus.collision_detected) begin
          state_d    = OVER;
          jump_req_d = 1'b0;
        end else begin
          if (tick_q) begin
            jump_req_d = 1'b0;
            if (h_q == 9'd0 && jump_pend) begin
              v_d = 9'(JUMP_VELOCITY - GRAVITY);
              h_d = 9'(JUMP_VELOCITY);
            end else if (h_q != 9'd0) begin
              if (hn[9] || hn == 10'sd0) begin
                h_d = 9'd0;
                v_d = 9'sd0;
              end else begin
                h_d = hn[8:0];
                v_d = v_q - 9'(GRAVITY);
              end
            end
            if (xo_q < 12'(OBST_SPEED)) begin
              xo_d = 12'(OBST_START_X);
              if (score_q != {SCORE_WIDTH{1'b1}})
                score_d = score_q + 1'b1;
            end else begin
              xo_d = xo_q - 12'(OBST_SPEED);
            end
          end else if (jump_press) begin
            jump_req_d = 1'b1;
          end
          if (pause_press) begin
            state_d    = PAUSED;
            jump_req_d = 1'b0;
          end
        end
      end
      PAUSED: begin
        if (pause_press) state_d = RUN;
      end
      OVER: begin
        if (jump_press) begin
          state_d = RUN;
          h_d     = 9'd0;
          v_d     = 9'sd0;
          xo_d    = 12'(OBST_START_X);
          score_d = '0;
        end
      end
      default: state_d = RUN;
    endcase

    y_d         = 12'(GROUND_Y) - {3'b000, h_d};
    game_over_d = (state_d == OVER);
    pause_d     = (state_d == PAUSED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      btn_s1_q    <= '0;
      btn_s2_q    <= '0;
      btn_prev_q  <= '0;
      press_q     <= '0;
      sr_prev_q   <= 1'b0;
      tick_q      <= 1'b0;
      jump_req_q  <= 1'b0;
      h_q         <= '0;
      v_q         <= '0;
      y_q         <= 12'(GROUND_Y);
      xo_q        <= 12'(OBST_START_X);
      score_q     <= '0;
      game_over_q <= 1'b0;
      pause_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      btn_s1_q    <= btn_s1_d;
      btn_s2_q    <= btn_s2_d;
      btn_prev_q  <= btn_prev_d;
      press_q     <= press_d;
      sr_prev_q   <= sr_prev_d;
      tick_q      <= tick_d;
      jump_req_q  <= jump_req_d;
      h_q         <= h_d;
      v_q         <= v_d;
      y_q         <= y_d;
      xo_q        <= xo_d;
      score_q     <= score_d;
      game_over_q <= game_over_d;
      pause_q     <= pause_d;
    end
  end

  assign bus.x_coor          = 32'(DINO_X);
  assign bus.y_coor          = {20'd0, y_q};
  assign bus.x_coor_obstacle = {20'd0, xo_q};
  assign bus.y_coor_obstacle = 32'(GROUND_Y);
  assign bus.game_over       = game_over_q;
  assign bus.pause           = pause_q;
  assign bus.score           = score_q;

endmodule
